// File: rtl/line_cntrl.sv
`default_nettype none
// ============================================================================
// line_cntrl : ping-pong line-buffer fill sequencer, display buffer select and
//              column-to-tile index conversion.                    rev 1.0
// ============================================================================
module line_cntrl #(
  parameter int WIDTH_PX       = 640,
  parameter int HEIGHT_LNS     = 480,
  parameter int TILE_WIDTH     = 4,
  parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int PXL_CTR_WIDTH  = $clog2(WIDTH_PX),
  parameter int LN_CTR_WIDTH   = $clog2(HEIGHT_LNS)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      frame_start_i,
  input  logic                      line_end_i,
  input  logic [PXL_CTR_WIDTH-1:0]  pxl_ctr_i,
  input  logic [1:0]                buff_fill_done_i,
  output logic [1:0]                buff_fill_req_o,
  output logic [1:0]                buff_sel_o,
  output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
  output logic [LN_CTR_WIDTH-1:0]   fill_ln_o,
  output logic                      underrun_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [LN_CTR_WIDTH-1:0] LAST_LN = LN_CTR_WIDTH'(HEIGHT_LNS - 1);
  localparam int                      TILE_SHIFT = $clog2(TILE_WIDTH);
  localparam bit                      TILE_POW2  = ((1 << TILE_SHIFT) == TILE_WIDTH);

  state_t                    state;
  logic [LN_CTR_WIDTH-1:0]   disp_ln;
  logic [1:0]                ready;
  logic [1:0]                done_hit;
  logic [1:0]                ready_upd;
  logic [1:0]                req_upd;
  logic [1:0]                next_buf;
  logic                      swap_ok;
  logic [TILE_CTR_WIDTH-1:0] tile_idx;

  generate
    if (TILE_POW2) begin : g_tile_shift
      assign tile_idx = TILE_CTR_WIDTH'(pxl_ctr_i >> TILE_SHIFT);
    end else begin : g_tile_div
      assign tile_idx = TILE_CTR_WIDTH'(pxl_ctr_i / TILE_WIDTH);
    end
  endgenerate

  // A done pulse only counts against its own outstanding request; a done
  // arriving with line_end_i in the same cycle already qualifies for the swap.
  always_comb begin
    done_hit  = buff_fill_done_i & buff_fill_req_o;
    ready_upd = ready | done_hit;
    req_upd   = buff_fill_req_o & ~done_hit;
    next_buf  = {buff_sel_o[0], buff_sel_o[1]};
    swap_ok   = |(ready_upd & next_buf);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= IDLE;
      buff_fill_req_o <= 2'b00;
      buff_sel_o      <= 2'b00;
      disp_pxl_id_o   <= '0;
      fill_ln_o       <= '0;
      underrun_o      <= 1'b0;
      disp_ln         <= '0;
      ready           <= 2'b00;
    end else begin
      disp_pxl_id_o <= tile_idx;
      case (state)
        IDLE: begin
          if (frame_start_i && en_i) begin
            state           <= PRIME;
            buff_fill_req_o <= 2'b01;
            fill_ln_o       <= '0;
            disp_ln         <= '0;
            ready           <= 2'b00;
            underrun_o      <= 1'b0;
          end
        end

        PRIME: begin
          if (done_hit[0]) begin
            state      <= ACTIVE;
            buff_sel_o <= 2'b01;
            ready      <= 2'b01;
            if (HEIGHT_LNS > 1) begin
              buff_fill_req_o <= 2'b10;
              fill_ln_o       <= LN_CTR_WIDTH'(1);
            end else begin
              buff_fill_req_o <= 2'b00;
            end
          end
        end

        ACTIVE: begin
          buff_fill_req_o <= req_upd;
          ready           <= ready_upd;
          if (line_end_i) begin
            if (disp_ln == LAST_LN) begin
              state           <= IDLE;
              buff_sel_o      <= 2'b00;
              ready           <= 2'b00;
              buff_fill_req_o <= 2'b00;
            end else if (swap_ok) begin
              // The buffer leaving display becomes the next fill target.
              buff_sel_o <= next_buf;
              ready      <= ready_upd & next_buf;
              disp_ln    <= disp_ln + LN_CTR_WIDTH'(1);
              if (fill_ln_o < LAST_LN) begin
                buff_fill_req_o <= req_upd | buff_sel_o;
                fill_ln_o       <= fill_ln_o + LN_CTR_WIDTH'(1);
              end
            end else begin
              // Repeat the current line but keep the line count frame-aligned.
              underrun_o <= 1'b1;
              disp_ln    <= disp_ln + LN_CTR_WIDTH'(1);
            end
          end
        end

        default: begin
          state           <= IDLE;
          buff_fill_req_o <= 2'b00;
          buff_sel_o      <= 2'b00;
          ready           <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_cntrl.sv
`default_nettype none
// ============================================================================
// tb_line_cntrl : scoreboard bench for line_cntrl (16x4 frame, 4-pixel tiles).
//                                                                   rev 1.0
// ============================================================================
module tb_line_cntrl;

  localparam int W = 16;
  localparam int H = 4;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic       frame_start = 1'b0;
  logic       line_end = 1'b0;
  logic [3:0] pxl_ctr = 4'd0;
  logic [1:0] done_in = 2'b00;
  logic [1:0] req;
  logic [1:0] sel;
  logic [1:0] pxl_id;
  logic [1:0] fill_ln;
  logic       underrun;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  bit stim_done = 1'b0;

  typedef struct {
    int         stamp;
    logic [6:0] val;
  } exp_t;

  exp_t ctlq[$];
  exp_t pxlq[$];

  line_cntrl #(
    .WIDTH_PX   (W),
    .HEIGHT_LNS (H),
    .TILE_WIDTH (T)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .en_i             (en),
    .frame_start_i    (frame_start),
    .line_end_i       (line_end),
    .pxl_ctr_i        (pxl_ctr),
    .buff_fill_done_i (done_in),
    .buff_fill_req_o  (req),
    .buff_sel_o       (sel),
    .disp_pxl_id_o    (pxl_id),
    .fill_ln_o        (fill_ln),
    .underrun_o       (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected control outputs after the edge that samples the current drive.
  task automatic exp_ctl(input logic [1:0] r, input logic [1:0] s,
                         input logic [1:0] f, input logic u);
    exp_t e;
    e.stamp = cyc + 1;
    e.val   = {r, s, f, u};
    ctlq.push_back(e);
  endtask

  task automatic exp_pxl(input logic [1:0] v);
    exp_t e;
    e.stamp = cyc + 1;
    e.val   = {5'd0, v};
    pxlq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic fs, input logic le, input logic [1:0] d);
    frame_start = fs;
    line_end    = le;
    done_in     = d;
    @(negedge clk);
    frame_start = 1'b0;
    line_end    = 1'b0;
    done_in     = 2'b00;
  endtask

  logic [1:0] tile_exp [16];

  initial begin
    exp_t e;
    tile_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    e.stamp = -1;
    e.val   = 7'd0;
    ctlq.push_back(e);
    e.stamp = 1;
    pxlq.push_back(e);
    #1 rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(1);

    // Prime then a clean full frame
    en = 1'b1;
    exp_ctl(2'b01, 2'b00, 2'd0, 1'b0); pulse(1'b1, 1'b0, 2'b00);
    step(4);
    exp_ctl(2'b10, 2'b01, 2'd1, 1'b0); pulse(1'b0, 1'b0, 2'b01);
    step(2);
    exp_ctl(2'b00, 2'b01, 2'd1, 1'b0); pulse(1'b0, 1'b0, 2'b10);
    step(15);
    exp_ctl(2'b01, 2'b10, 2'd2, 1'b0); pulse(1'b0, 1'b1, 2'b00);
    step(2);
    exp_ctl(2'b00, 2'b10, 2'd2, 1'b0); pulse(1'b0, 1'b0, 2'b01);
    step(15);
    exp_ctl(2'b10, 2'b01, 2'd3, 1'b0); pulse(1'b0, 1'b1, 2'b00);
    step(2);
    exp_ctl(2'b00, 2'b01, 2'd3, 1'b0); pulse(1'b0, 1'b0, 2'b10);
    step(15);
    exp_ctl(2'b00, 2'b10, 2'd3, 1'b0); pulse(1'b0, 1'b1, 2'b00);
    step(19);
    exp_ctl(2'b00, 2'b00, 2'd3, 1'b0); pulse(1'b0, 1'b1, 2'b00);
    step(5);

    // Underrun frame: done[1] held back past the first line end
    exp_ctl(2'b01, 2'b00, 2'd0, 1'b0); pulse(1'b1, 1'b0, 2'b00);
    step(4);
    exp_ctl(2'b10, 2'b01, 2'd1, 1'b0); pulse(1'b0, 1'b0, 2'b01);
    step(10);
    exp_ctl(2'b10, 2'b01, 2'd1, 1'b1); pulse(1'b0, 1'b1, 2'b00);
    step(3);
    exp_ctl(2'b00, 2'b01, 2'd1, 1'b1); pulse(1'b0, 1'b0, 2'b10);
    step(10);
    exp_ctl(2'b01, 2'b10, 2'd2, 1'b1); pulse(1'b0, 1'b1, 2'b00);
    step(2);
    exp_ctl(2'b00, 2'b10, 2'd2, 1'b1); pulse(1'b0, 1'b0, 2'b01);
    step(10);
    exp_ctl(2'b10, 2'b01, 2'd3, 1'b1); pulse(1'b0, 1'b1, 2'b00);
    step(2);
    exp_ctl(2'b00, 2'b01, 2'd3, 1'b1); pulse(1'b0, 1'b0, 2'b10);
    step(10);
    exp_ctl(2'b00, 2'b00, 2'd3, 1'b1); pulse(1'b0, 1'b1, 2'b00);
    step(5);

    // Same-cycle done[1] and line end; underrun cleared by the new frame
    exp_ctl(2'b01, 2'b00, 2'd0, 1'b0); pulse(1'b1, 1'b0, 2'b00);
    step(4);
    exp_ctl(2'b10, 2'b01, 2'd1, 1'b0); pulse(1'b0, 1'b0, 2'b01);
    step(5);
    exp_ctl(2'b01, 2'b10, 2'd2, 1'b0); pulse(1'b0, 1'b1, 2'b10);
    step(2);

    // Tile index sweep, one cycle late
    for (int i = 0; i < 16; i++) begin
      pxl_ctr = 4'(i);
      exp_pxl(tile_exp[i]);
      @(negedge clk);
    end
    pxl_ctr = 4'd13;
    exp_pxl(2'd3);
    @(negedge clk);

    // Asynchronous reset mid-ACTIVE: outputs clear before the next edge
    exp_ctl(2'b00, 2'b00, 2'd0, 1'b0);
    exp_pxl(2'd0);
    @(posedge clk);
    #1 rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    pxl_ctr = 4'd0;
    step(2);

    // Stray dones in IDLE, frame start with enable low, stray done in PRIME
    pulse(1'b0, 1'b0, 2'b01);
    step(1);
    pulse(1'b0, 1'b0, 2'b10);
    step(1);
    en = 1'b0;
    pulse(1'b1, 1'b0, 2'b00);
    step(3);
    en = 1'b1;
    exp_ctl(2'b01, 2'b00, 2'd0, 1'b0); pulse(1'b1, 1'b0, 2'b00);
    step(2);
    pulse(1'b0, 1'b0, 2'b10);
    step(2);
    exp_ctl(2'b10, 2'b01, 2'd1, 1'b0); pulse(1'b0, 1'b0, 2'b01);
    step(5);
    stim_done = 1'b1;
  end

  logic [6:0] prev = 7'd0;
  bit         first = 1'b1;

  always @(negedge clk) begin
    logic [6:0] snap;
    exp_t       e;
    snap = {req, sel, fill_ln, underrun};
    if (first || snap != prev) begin
      n_vec++;
      if (ctlq.size() == 0) begin
        n_fail++;
        $display("FAIL ctl_unexpected cyc=%0d got req=%b sel=%b fill_ln=%0d underrun=%b, expected no change",
                 cyc, req, sel, fill_ln, underrun);
      end else begin
        e = ctlq.pop_front();
        if ((e.stamp >= 0 && e.stamp != cyc) || snap !== e.val) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d got req=%b sel=%b fill_ln=%0d underrun=%b, expected req=%b sel=%b fill_ln=%0d underrun=%b at cyc=%0d",
                   cyc, req, sel, fill_ln, underrun,
                   e.val[6:5], e.val[4:3], e.val[2:1], e.val[0], e.stamp);
        end
      end
    end
    prev  = snap;
    first = 1'b0;

    while (pxlq.size() > 0 && pxlq[0].stamp <= cyc) begin
      e = pxlq.pop_front();
      n_vec++;
      if (e.stamp != cyc || {5'd0, pxl_id} !== e.val) begin
        n_fail++;
        $display("FAIL tile_idx cyc=%0d got=%0d, expected=%0d at cyc=%0d",
                 cyc, pxl_id, e.val[1:0], e.stamp);
      end
    end

    if (stim_done) begin
      n_vec++;
      if (ctlq.size() != 0 || pxlq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover got ctl=%0d pxl=%0d pending, expected 0 pending",
                 ctlq.size(), pxlq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

endmodule
`default_nettype wire
